// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch port and a data port.
// Data normally wins contention, but instruction fetches are guaranteed service after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  // instruction port
  input  logic [31:0] imem_address_i,
  input  logic        imem_read_i,
  output logic [31:0] imem_data_o,
  output logic        imem_data_ready_o,
  // data port
  input  logic [31:0] dmem_address_i,
  input  logic [31:0] dmem_data_i,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [3:0]  dmem_sel_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_data_ready_o,
  // shared memory
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_sel_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IGRANT = 2'd1,
    ST_DGRANT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic dmem_req;
  assign dmem_req = dmem_read_i | dmem_write_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!imem_read_i) starve_d = '0;
        if (imem_read_i && (!dmem_req || starve_q == LIMIT)) begin
          state_d     = ST_IGRANT;
          starve_d    = '0;
          mem_addr_d  = imem_address_i;
          mem_wdata_d = '0;
          mem_sel_d   = 4'b1111;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end else if (dmem_req) begin
          state_d     = ST_DGRANT;
          mem_addr_d  = dmem_address_i;
          mem_wdata_d = dmem_data_i;
          mem_sel_d   = dmem_sel_i;
          // A write strobe takes priority over a simultaneous read strobe.
          mem_write_d = dmem_write_i;
          mem_read_d  = ~dmem_write_i;
          if (imem_read_i)
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
        end
      end
      ST_IGRANT, ST_DGRANT: begin
        if (mem_ready_i) begin
          state_d     = ST_DONE;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_sel_d   = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion is signalled combinationally in the cycle the memory reports ready.
  always_comb begin
    imem_data_ready_o = (state_q == ST_IGRANT) && mem_ready_i;
    dmem_data_ready_o = (state_q == ST_DGRANT) && mem_ready_i;
    imem_data_o       = imem_data_ready_o ? mem_data_i : '0;
    dmem_data_o       = dmem_data_ready_o ? mem_data_i : '0;
    unique case (state_q)
      ST_IGRANT: grant_o = 2'b01;
      ST_DGRANT: grant_o = 2'b10;
      default:   grant_o = 2'b00;
    endcase
  end

  assign mem_address_o = mem_addr_q;
  assign mem_data_o    = mem_wdata_q;
  assign mem_sel_o     = mem_sel_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits; range 0..15.
REQ-002 clock_i  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n_i  in  1  reset, asynchronous and active-low.
REQ-004 imem_address_i  in  32  instruction fetch address.
REQ-005 imem_read_i  in  1  instruction fetch request; held by requester until imem_data_ready_o.
REQ-006 imem_data_o  out  32  instruction read data.
REQ-007 imem_data_ready_o  out  1  instruction transaction complete, one-cycle pulse.
REQ-008 dmem_address_i  in  32  data address.
REQ-009 dmem_data_i  in  32  data write value.
REQ-010 dmem_read_i / dmem_write_i  in  1 each  data read / write request; held until dmem_data_ready_o.
REQ-011 dmem_sel_i  in  4  byte-lane select.
REQ-012 dmem_data_o  out  32  data read value.
REQ-013 dmem_data_ready_o  out  1  data transaction complete, one-cycle pulse.
REQ-014 mem_address_o  out  32  shared memory address.
REQ-015 mem_data_o  out  32  shared memory write data.
REQ-016 mem_read_o / mem_write_o  out  1 each  shared memory read / write strobe.
REQ-017 mem_sel_o  out  4  shared memory byte select.
REQ-018 mem_data_i  in  32  shared memory read data.
REQ-019 mem_ready_i  in  1  shared memory transaction complete.
REQ-020 grant_o  out  2  current owner: 00 none, 01 instruction, 10 data.

Function
REQ-021 FSM states SHALL be IDLE, IGRANT, DGRANT, DONE.
REQ-022 IDLE: no request -> stay; requests sampled on clock edge; grant chosen per REQ-023/024.
REQ-023 Only one port requesting -> that port granted.
REQ-024 Both requesting -> data granted unless starve_count == STARVE_LIMIT, then instruction granted; STARVE_LIMIT=0 -> instruction always wins.
REQ-025 On grant, mem_address_o, mem_data_o, mem_sel_o, mem_read_o, mem_write_o SHALL be registered from the winning port; visible the cycle after the IDLE decision cycle (1-cycle issue latency).
REQ-026 Instruction grant: mem_read_o=1, mem_write_o=0, mem_sel_o=4'b1111, mem_data_o=0.
REQ-027 Data grant with dmem_write_i=1: mem_write_o=1, mem_read_o=0 (write wins if both dmem strobes high); else mem_read_o=1.
REQ-028 mem_read_o and mem_write_o SHALL never be high together.
REQ-029 IGRANT/DGRANT: downstream outputs held stable until mem_ready_i=1; no cycle limit.
REQ-030 Completion cycle (mem_ready_i=1 in IGRANT/DGRANT): granted port ready_o=1 combinationally, its data_o=mem_data_i; strobes deassert next edge; go to DONE.
REQ-031 DONE: exactly one cycle, no grant, no strobes (lets requester drop or change request); then IDLE.
REQ-032 Non-granted port ready_o SHALL be 0; mem_ready_i outside IGRANT/DGRANT ignored.
REQ-033 imem_data_o/dmem_data_o SHALL be 0 except in that port's completion cycle.
REQ-034 starve_count (4 bit): +1 on data grant while imem_read_i=1, saturating at STARVE_LIMIT; cleared on instruction grant or when imem_read_i=0 in IDLE.
REQ-035 Requests dropped before grant are not issued; request changes during IGRANT/DGRANT are ignored.
REQ-036 grant_o reflects state: IGRANT 01, DGRANT 10, else 00.

Reset
REQ-037 reset_n_i low SHALL immediately force IDLE, starve_count=0, all outputs 0, including mid-transaction; abandoned transaction never completes to a requester.
REQ-038 First grant possible at first rising edge after reset_n_i deasserts.

Verification
REQ-039 Single fetch: imem_read_i=1, addr 0x100, memory ready 2 cycles later with 0xDEADBEEF -> mem_read_o at cycle 1, imem_data_ready_o one pulse with imem_data_o=0xDEADBEEF, grant_o 01 then 00.
REQ-040 Data write: dmem_write_i=1, addr 0x200, data 0x12345678, sel 0011 -> mem_write_o=1, mem_sel_o=0011, mem_data_o=0x12345678, dmem_data_ready_o one pulse, mem_read_o=0 throughout.
REQ-041 Contention, STARVE_LIMIT=4, both requests held continuously, data re-requests after each completion -> grant order D,D,D,D,I,D,...
REQ-042 STARVE_LIMIT=0, both requests -> instruction granted first.
REQ-043 reset_n_i pulsed low during DGRANT with mem_ready_i=1 next cycle -> all outputs 0 asynchronously, no dmem_data_ready_o pulse, grant_o=00.
REQ-044 dmem_read_i and dmem_write_i both 1 -> write issued, strobes never both high.
